seq_divider: RTL and testbench

Parametrised multi-cycle restoring divider. It is the successor to the fixed 8/7-bit divider and generalises operand widths. It adds a busy/valid handshake, divide-by-zero detection, and optional signed mode. It sits beside the arithmetic blocks and is driven by a requester that pulses start and polls valid.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_ctrl.sv | 62 ++++++
 rtl/seq_divider.sv | 110 +++++++++++
 tb/tb_seq_divider.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants for the multi-cycle restoring divider: state encoding,
// default operand widths and the iteration-counter width helper.
package seq_divider_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_ctrl.sv
// Divider sequencer: IDLE/RUN/DONE FSM plus iteration counter, emitting
// load/iterate/finish strobes for the datapath.
module seq_divider_ctrl
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic dz_i,
  output logic load_o,
  output logic iter_o,
  output logic fin_o,
  output logic busy_o,
  output logic valid_o
);

  localparam int CW = cnt_w(DIVIDEND_W);
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign load_o  = start_i && (state_q != ST_RUN);
  assign iter_o  = (state_q == ST_RUN);
  // A zero divisor finishes on the first RUN edge instead of iterating.
  assign fin_o   = (state_q == ST_RUN) && (dz_i || (cnt_q == LAST));
  assign busy_o  = (state_q == ST_RUN);
  assign valid_o = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (fin_o) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Parametrised restoring divider with busy/valid handshake and divide-by-zero
// flag. Define SIGNED_DIV_EN to add the sgn port and two's-complement mode.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividendin,
  input  logic [DIVISOR_W-1:0]  divisorin,
  output logic                  busy,
  output logic                  valid,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  dbz
`ifdef SIGNED_DIV_EN
  ,
  input  logic                  sgn
`endif
);

  if (DIVIDEND_W < 2 || DIVIDEND_W > 32 || DIVISOR_W < 2 || DIVISOR_W > DIVIDEND_W) begin : g_bad_w
    $error("seq_divider: illegal DIVIDEND_W/DIVISOR_W combination");
  end

  logic s;
`ifdef SIGNED_DIV_EN
  assign s = sgn;
`else
  assign s = 1'b0;
`endif

  logic load, iter, fin;
  logic [DIVIDEND_W-1:0] dvd_q, quo_q;
  logic [DIVISOR_W-1:0]  pr_q, dvs_q, rem_q;
  logic                  dz_q, neg_q, rneg_q, dbz_q;

  seq_divider_ctrl #(.DIVIDEND_W(DIVIDEND_W)) u_ctrl (
    .clk_i   (clk),
    .rst_ni  (reset),
    .start_i (start),
    .dz_i    (dz_q),
    .load_o  (load),
    .iter_o  (iter),
    .fin_o   (fin),
    .busy_o  (busy),
    .valid_o (valid)
  );

  // Operand magnitudes; the RUN loop is always unsigned.
  logic                  dvd_neg, dvs_neg;
  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  assign dvd_neg = s & dividendin[DIVIDEND_W-1];
  assign dvs_neg = s & divisorin[DIVISOR_W-1];
  assign dvd_mag = dvd_neg ? -dividendin : dividendin;
  assign dvs_mag = dvs_neg ? -divisorin : divisorin;

  logic [DIVISOR_W:0]    pr_sh, sub;
  logic                  qbit;
  logic [DIVISOR_W-1:0]  pr_nx, r_fix;
  logic [DIVIDEND_W-1:0] dvd_nx, q_fix;
  always_comb begin
    pr_sh  = {pr_q, dvd_q[DIVIDEND_W-1]};
    qbit   = (pr_sh >= {1'b0, dvs_q});
    sub    = pr_sh - {1'b0, dvs_q};
    pr_nx  = DIVISOR_W'(qbit ? sub : pr_sh);
    dvd_nx = {dvd_q[DIVIDEND_W-2:0], qbit};
    q_fix  = neg_q ? -dvd_nx : dvd_nx;
    r_fix  = rneg_q ? -pr_nx : pr_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd_q  <= '0;
      pr_q   <= '0;
      dvs_q  <= '0;
      dz_q   <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (load) begin
      dvd_q  <= dvd_mag;
      pr_q   <= '0;
      dvs_q  <= dvs_mag;
      dz_q   <= (divisorin == '0);
      neg_q  <= dvd_neg ^ dvs_neg;
      rneg_q <= dvd_neg;
      dbz_q  <= 1'b0;
    end else if (iter) begin
      dvd_q <= dvd_nx;
      pr_q  <= pr_nx;
      if (fin) begin
        quo_q <= dz_q ? '1 : q_fix;
        rem_q <= dz_q ? '0 : r_fix;
        dbz_q <= dz_q;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: default 8/7 instance plus a 16/12 instance.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [6:0]  b = '0;
  logic        busy, valid, dbz;
  logic [7:0]  q;
  logic [6:0]  r;
  logic        start2 = 1'b0;
  logic [15:0] a2 = '0;
  logic [11:0] b2 = '0;
  logic        busy2, valid2, dbz2;
  logic [15:0] q2;
  logic [11:0] r2;
  logic        sg = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk(clk), .reset(reset), .start(start), .dividendin(a), .divisorin(b),
    .busy(busy), .valid(valid), .quotient(q), .remainder(r), .dbz(dbz)
`ifdef SIGNED_DIV_EN
    , .sgn(sg)
`endif
  );

  seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(12)) dut16 (
    .clk(clk), .reset(reset), .start(start2), .dividendin(a2), .divisorin(b2),
    .busy(busy2), .valid(valid2), .quotient(q2), .remainder(r2), .dbz(dbz2)
`ifdef SIGNED_DIV_EN
    , .sgn(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] da, input logic [6:0] db, input logic s);
    @(negedge clk);
    start = 1'b1; a = da; b = db; sg = s;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [7:0] da, input logic [6:0] db,
                     input logic s, input logic [7:0] eq, input logic [6:0] er);
    go(da, db, s);
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_hs"}, {valid, busy, dbz}, 3'b100);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
  endtask

  initial begin
    #12;
    chk("rst_state", {busy, valid, dbz, q, r}, '0);
    @(negedge clk) reset = 1'b1;

    // 200/7 with busy tracked cycle by cycle
    go(8'd200, 7'd7, 1'b0);
    chk("busy_e0", {busy, valid}, 2'b10);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk("busy_run", {busy, valid, q}, {2'b10, 8'd0});
    end
    @(posedge clk); #1;
    chk("done_hs", {valid, busy, dbz}, 3'b100);
    chk("200_7_q", q, 8'd28);
    chk("200_7_r", r, 7'd4);

    run("255_127", 8'd255, 7'd127, 1'b0, 8'd2, 7'd1);
    run("5_100", 8'd5, 7'd100, 1'b0, 8'd0, 7'd5);

    // divide by zero
    go(8'd13, 7'd0, 1'b0);
    chk("dbz_e0", {busy, valid}, 2'b10);
    @(posedge clk); #1;
    chk("dbz_flags", {valid, dbz, busy}, 3'b110);
    chk("dbz_q", q, 8'hFF);
    chk("dbz_r", r, 7'd0);
    run("9_3", 8'd9, 7'd3, 1'b0, 8'd3, 7'd0);

    // start held during RUN is ignored
    go(8'd200, 7'd7, 1'b0);
    start = 1'b1; a = 8'd50; b = 7'd5;
    repeat (8) @(posedge clk);
    #1 start = 1'b0;
    chk("ign_hs", {valid, busy}, 2'b10);
    chk("ign_q", q, 8'd28);
    chk("ign_r", r, 7'd4);
    go(8'd50, 7'd5, 1'b0);
    chk("restart_drop", {valid, busy, q}, {2'b01, 8'd28});
    repeat (8) @(posedge clk);
    #1;
    chk("50_5", {valid, q, r}, {1'b1, 8'd10, 7'd0});

    // asynchronous reset after iteration 4
    go(8'd200, 7'd7, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst", {busy, valid, dbz, q, r}, '0);
    @(negedge clk) reset = 1'b1;
    run("100_9", 8'd100, 7'd9, 1'b0, 8'd11, 7'd1);

    // wide instance
    @(negedge clk);
    start2 = 1'b1; a2 = 16'd65535; b2 = 12'd4095;
    @(posedge clk);
    #1 start2 = 1'b0;
    chk("w16_busy", {busy2, valid2}, 2'b10);
    repeat (15) @(posedge clk);
    #1;
    chk("w16_e15", {busy2, valid2}, 2'b10);
    @(posedge clk); #1;
    chk("w16_hs", {valid2, busy2, dbz2}, 3'b100);
    chk("w16_q", q2, 16'd16);
    chk("w16_r", r2, 12'd15);

`ifdef SIGNED_DIV_EN
    run("s_m100_7", 8'h9C, 7'd7, 1'b1, 8'hF2, 7'h7E);
    run("s_100_m7", 8'd100, 7'h79, 1'b1, 8'hF2, 7'd2);
    run("s_m128_m1", 8'h80, 7'h7F, 1'b1, 8'h80, 7'd0);
    run("u_200_7", 8'd200, 7'd7, 1'b0, 8'd28, 7'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
